// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// DM has priority with an IF anti-starvation run limit; responses are routed by an in-order tag FIFO.
module mem_port_arbiter #(
    parameter int MAX_OUTST  = 2,
    parameter int MAX_DM_RUN = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    input  logic        i_dm_req,
    input  logic [31:0] i_dm_addr,
    input  logic        i_dm_wr,
    input  logic [3:0]  i_dm_strb,
    input  logic [31:0] i_dm_wdata,
    output logic        o_dm_gnt,
    output logic        o_dm_rvalid,
    output logic [31:0] o_dm_rdata,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wr,
    output logic [3:0]  o_mem_strb,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy,
    output logic        o_err
);

    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int RW = $clog2(MAX_DM_RUN + 1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTST);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTST - 1);
    localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_DM_RUN);

    logic [MAX_OUTST-1:0] tag_q, tag_d;
    logic [PW-1:0]        wptr_q, wptr_d;
    logic [PW-1:0]        rptr_q, rptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [RW-1:0]        run_q, run_d;
    logic                 err_q, err_d;

    logic can_issue;
    logic sel_dm;
    logic mem_req;
    logic accept;
    logic resp;
    logic head;

    always_comb begin
        can_issue = (cnt_q < CNT_MAX) || i_mem_rvalid;
        sel_dm    = i_dm_req && !(i_if_req && (run_q == RUN_MAX));
        mem_req   = i_rst && can_issue && (i_if_req || i_dm_req);
        accept    = mem_req && i_mem_gnt;
        resp      = i_rst && i_mem_rvalid && (cnt_q != '0);
        head      = tag_q[rptr_q];
    end

    always_comb begin
        o_mem_req   = mem_req;
        o_mem_addr  = '0;
        o_mem_wr    = 1'b0;
        o_mem_strb  = '0;
        o_mem_wdata = '0;
        if (mem_req && sel_dm) begin
            o_mem_addr  = i_dm_addr;
            o_mem_wr    = i_dm_wr;
            o_mem_strb  = i_dm_strb;
            o_mem_wdata = i_dm_wdata;
        end else if (mem_req) begin
            o_mem_addr  = i_if_addr;
        end
        o_if_gnt    = accept && !sel_dm;
        o_dm_gnt    = accept && sel_dm;
        o_if_rvalid = resp && !head;
        o_dm_rvalid = resp && head;
        o_if_rdata  = i_rst ? i_mem_rdata : '0;
        o_dm_rdata  = i_rst ? i_mem_rdata : '0;
        o_busy      = (cnt_q != '0);
        o_err       = err_q;
    end

    always_comb begin
        tag_d  = tag_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        err_d  = err_q | (i_mem_rvalid && (cnt_q == '0));
        if (accept) begin
            tag_d[wptr_q] = sel_dm;
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PW'(1);
        end
        if (resp) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PW'(1);
        end
        if (accept && !resp) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!accept && resp) begin
            cnt_d = cnt_q - CW'(1);
        end
        // run counts DM wins only while IF is actually waiting
        if (!i_if_req || o_if_gnt) begin
            run_d = '0;
        end else if (o_dm_gnt && (run_q != RUN_MAX)) begin
            run_d = run_q + RW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            tag_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            run_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            tag_q  <= tag_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with an in-order memory model
// and a response scoreboard (tag, data, arrival cycle).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_if_req = 1'b0;
    logic [31:0] i_if_addr = '0;
    logic        i_dm_req = 1'b0;
    logic [31:0] i_dm_addr = '0;
    logic        i_dm_wr = 1'b0;
    logic [3:0]  i_dm_strb = '0;
    logic [31:0] i_dm_wdata = '0;
    logic        i_mem_gnt = 1'b1;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    logic        o_if_gnt, o_if_rvalid, o_dm_gnt, o_dm_rvalid;
    logic [31:0] o_if_rdata, o_dm_rdata, o_mem_addr, o_mem_wdata;
    logic        o_mem_req, o_mem_wr, o_busy, o_err;
    logic [3:0]  o_mem_strb;

    mem_port_arbiter #(.MAX_OUTST(2), .MAX_DM_RUN(4)) dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_dm_req(i_dm_req), .i_dm_addr(i_dm_addr), .i_dm_wr(i_dm_wr),
        .i_dm_strb(i_dm_strb), .i_dm_wdata(i_dm_wdata),
        .o_dm_gnt(o_dm_gnt), .o_dm_rvalid(o_dm_rvalid), .o_dm_rdata(o_dm_rdata),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_wr(o_mem_wr),
        .o_mem_strb(o_mem_strb), .o_mem_wdata(o_mem_wdata),
        .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;
    int lat = 1;
    logic mem_auto = 1'b1;
    logic gnt_nxt = 1'b1;
    logic auto_rv = 1'b0;
    logic [31:0] auto_rd = '0;
    logic man_rv = 1'b0;

    assign i_mem_rvalid = mem_auto ? auto_rv : man_rv;
    assign i_mem_rdata  = mem_auto ? auto_rd : 32'h0;

    typedef struct {
        logic [31:0] addr;
        int          rdy;
    } pend_t;
    typedef struct {
        logic        dm;
        logic        chk;
        logic [31:0] data;
        int          due;
    } exp_t;

    pend_t pend[$];
    exp_t  sb[$];
    exp_t  rsp_e;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // memory model: in-order, fixed latency, one response per accept
    always @(negedge clk) begin
        if (!rst_n) begin
            pend.delete();
        end else if (mem_auto) begin
            if (i_mem_rvalid && pend.size() != 0) void'(pend.pop_front());
            if (o_mem_req && i_mem_gnt) pend.push_back('{o_mem_addr, cyc + lat});
        end
    end

    always begin
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        if (pend.size() != 0 && pend[0].rdy <= cyc) begin
            auto_rv = 1'b1;
            auto_rd = mdata(pend[0].addr);
        end else begin
            auto_rv = 1'b0;
            auto_rd = '0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && (o_if_rvalid || o_dm_rvalid)) begin
            chk("rsp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                rsp_e = sb.pop_front();
                chk("rsp_tag", 32'({o_dm_rvalid, o_if_rvalid}), rsp_e.dm ? 32'd2 : 32'd1);
                chk("rsp_cycle", 32'(cyc), 32'(rsp_e.due));
                if (rsp_e.chk)
                    chk("rsp_data", rsp_e.dm ? o_dm_rdata : o_if_rdata, rsp_e.data);
            end
        end
    end

    task automatic step(input string t,
                        input logic ir, input logic [31:0] ia,
                        input logic dr, input logic [31:0] da, input logic dw,
                        input logic [3:0] ds, input logic [31:0] dd,
                        input logic eig, input logic edg, input logic emr);
        @(posedge clk);
        #1;
        i_if_req = ir; i_if_addr = ia;
        i_dm_req = dr; i_dm_addr = da; i_dm_wr = dw;
        i_dm_strb = ds; i_dm_wdata = dd;
        i_mem_gnt = gnt_nxt;
        @(negedge clk);
        chk({t, "_ifgnt"}, 32'(o_if_gnt), 32'(eig));
        chk({t, "_dmgnt"}, 32'(o_dm_gnt), 32'(edg));
        chk({t, "_memreq"}, 32'(o_mem_req), 32'(emr));
        if (eig) begin
            chk({t, "_ifaddr"}, o_mem_addr, ia);
            chk({t, "_ifwr"}, 32'({o_mem_wr, o_mem_strb}), 32'h0);
            chk({t, "_ifwd"}, o_mem_wdata, 32'h0);
            sb.push_back('{1'b0, 1'b1, mdata(ia), cyc + lat});
        end
        if (edg) begin
            chk({t, "_dmaddr"}, o_mem_addr, da);
            chk({t, "_dmwr"}, 32'({o_mem_wr, o_mem_strb}), 32'({dw, ds}));
            if (dw) chk({t, "_dmwd"}, o_mem_wdata, dd);
            sb.push_back('{1'b1, !dw, mdata(da), cyc + lat});
        end
        if (!emr) chk({t, "_idleaddr"}, o_mem_addr, 32'h0);
    endtask

    task automatic if_rd(input string t, input logic [31:0] a, input logic g, input logic r);
        step(t, 1'b1, a, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, g, 1'b0, r);
    endtask

    task automatic idle(input string t);
        step(t, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input string t);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({t, "_drain"}, 32'(sb.size()), 32'h0);
        idle({t, "_settle"});
        chk({t, "_busy"}, 32'(o_busy), 32'h0);
    endtask

    task automatic pulse_rvalid(input string t);
        mem_auto = 1'b0;
        @(posedge clk);
        #1 man_rv = 1'b1;
        @(negedge clk);
        chk({t, "_norv"}, 32'({o_if_rvalid, o_dm_rvalid}), 32'h0);
        @(posedge clk);
        #1 man_rv = 1'b0;
        @(negedge clk);
        chk({t, "_err"}, 32'(o_err), 32'h1);
        mem_auto = 1'b1;
    endtask

    int nif;
    int ndm;
    logic ex_if;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_outs", 32'({o_mem_req, o_if_gnt, o_dm_gnt, o_if_rvalid,
                             o_dm_rvalid, o_busy, o_err}), 32'h0);
        chk("rst_addr", o_mem_addr, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        lat = 1;
        if_rd("t1_0", 32'h0, 1'b1, 1'b1);
        if_rd("t1_4", 32'h4, 1'b1, 1'b1);
        if_rd("t1_8", 32'h8, 1'b1, 1'b1);
        idle("t1_idle");
        drain("t1");

        nif = 0;
        ndm = 0;
        for (int i = 0; i < 10; i++) begin
            ex_if = ((i % 5) == 4);
            step("t2", 1'b1, 32'h1000 + 32'(4 * nif), 1'b1, 32'h2000 + 32'(4 * ndm),
                 1'b0, 4'h0, 32'h0, ex_if, !ex_if, 1'b1);
            if (ex_if) nif++;
            else ndm++;
        end
        idle("t2_idle");
        drain("t2");

        lat = 3;
        if_rd("t3_a", 32'h100, 1'b1, 1'b1);
        if_rd("t3_b", 32'h104, 1'b1, 1'b1);
        if_rd("t3_stall", 32'h108, 1'b0, 1'b0);
        chk("t3_busy", 32'(o_busy), 32'h1);
        if_rd("t3_c", 32'h108, 1'b1, 1'b1);
        if_rd("t3_d", 32'h10C, 1'b1, 1'b1);
        idle("t3_idle");
        drain("t3");

        lat = 1;
        gnt_nxt = 1'b0;
        if_rd("t5_hold", 32'h300, 1'b0, 1'b1);
        gnt_nxt = 1'b1;
        if_rd("t5_go", 32'h300, 1'b1, 1'b1);
        idle("t5_idle");
        drain("t5");

        step("t4_st", 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 4'h3, 32'hDEADBEEF,
             1'b0, 1'b1, 1'b1);
        if_rd("t4_rd", 32'h44, 1'b1, 1'b1);
        idle("t4_idle");
        drain("t4");

        pulse_rvalid("t6");
        repeat (3) idle("t6_idle");
        chk("t6_sticky", 32'(o_err), 32'h1);

        lat = 3;
        if_rd("t7_a", 32'h200, 1'b1, 1'b1);
        if_rd("t7_b", 32'h204, 1'b1, 1'b1);
        chk("t7_busy", 32'(o_busy), 32'h1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t7_async", 32'({o_busy, o_err, o_mem_req, o_if_gnt}), 32'h0);
        i_if_req = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("t7_outs", 32'({o_mem_req, o_if_gnt, o_dm_gnt, o_if_rvalid,
                            o_dm_rvalid, o_busy, o_err}), 32'h0);
        chk("t7_rdata", o_if_rdata | o_dm_rdata | o_mem_addr, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t7_rel_busy", 32'(o_busy), 32'h0);
        chk("t7_rel_err", 32'(o_err), 32'h0);
        pulse_rvalid("t7_late");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
